// File: rtl/alu4_pkg.sv
// alu4_pkg: shared definitions for the 4-bit ALU, its BIST engine and bench.
//   DW            data width of the ALU operands/result
//   OP_*          SEL encodings
//   bist_st_e     BIST controller state encoding
//   alu4_expect() golden model of the ALU (results mod 16)
package alu4_pkg;

  localparam int DW    = 4;
  localparam int IDX_W = 2 + 2 * DW;       // {SEL, A, B}
  localparam int ERR_W = IDX_W + 1;        // holds 0..1024

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } bist_st_e;

  function automatic logic [DW-1:0] alu4_expect(input logic [1:0]    sel,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (sel)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu4_bist_if.sv
// alu4_bist_if: operand/result bus between the BIST engine and the ALU.
//   A_out, B_out, SEL_out  operands and opcode driven by the BIST (master)
//   Y_in                   combinational ALU result returned to the BIST
interface alu4_bist_if;
  import alu4_pkg::*;

  logic [DW-1:0] A_out;
  logic [DW-1:0] B_out;
  logic [1:0]    SEL_out;
  logic [DW-1:0] Y_in;

  modport master (output A_out, B_out, SEL_out, input  Y_in);
  modport slave  (input  A_out, B_out, SEL_out, output Y_in);
endinterface

// File: rtl/alu4_bist_ctrl.sv
// alu4_bist_ctrl: sweep sequencer for the ALU BIST.
//   clk_i, rst_ni  clock, async active-low reset
//   start_i        level start request (accepted in IDLE/FIN only)
//   idx_o          current vector {SEL,A,B}; registered, drives the ALU
//   cmp_en_o       high during the last hold cycle of a vector
//   last_o         cmp_en_o for vector 1023
//   clr_o          high in the cycle a new sweep is accepted
//   busy_o/done_o  registered status
module alu4_bist_ctrl
  import alu4_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             cmp_en_o,
  output logic             last_o,
  output logic             clr_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]    SET_MAX = SW'(SETTLE);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  bist_st_e         state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SW-1:0]    set_q;
  logic             busy_q, done_q;

  assign cmp_en_o = (state_q == ST_RUN) && (set_q == SET_MAX);
  assign last_o   = cmp_en_o && (idx_q == IDX_MAX);
  assign clr_o    = (state_q != ST_RUN) && start_i;
  assign idx_o    = idx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (set_q == SET_MAX) begin
            set_q <= '0;
            idx_q <= idx_q + IDX_W'(1);   // wraps to 0 after 1023
            if (idx_q == IDX_MAX) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            set_q <= set_q + SW'(1);
          end
        end
        default: begin                    // IDLE and FIN behave alike on START
          if (start_i) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            set_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/alu4_bist.sv
// alu4_bist: exhaustive self-test of the 4-bit ALU alu4_s1.
//   CLK_in, RST_N_in  clock, async active-low reset
//   START_in          level start request
//   alu               operand/result bus to the ALU (master side)
//   BUSY, DONE, PASS  sweep status; PASS = DONE with no mismatches
//   ERR_CNT           mismatching vectors seen in the current/last sweep
//   FAIL_VEC, FAIL_Y  {SEL,A,B} and Y of the first mismatch (0 if none)
module alu4_bist
  import alu4_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic             CLK_in,
  input  logic             RST_N_in,
  input  logic             START_in,
  alu4_bist_if.master      alu,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [IDX_W-1:0] FAIL_VEC,
  output logic [DW-1:0]    FAIL_Y
);

  logic [IDX_W-1:0] idx;
  logic             cmp_en, last, clr;

  alu4_bist_ctrl #(.SETTLE(SETTLE)) u_ctrl (
    .clk_i    (CLK_in),
    .rst_ni   (RST_N_in),
    .start_i  (START_in),
    .idx_o    (idx),
    .cmp_en_o (cmp_en),
    .last_o   (last),
    .clr_o    (clr),
    .busy_o   (BUSY),
    .done_o   (DONE)
  );

  // idx is already a register, so the ALU operands are registered copies.
  assign alu.SEL_out = idx[IDX_W-1 -: 2];
  assign alu.A_out   = idx[2*DW-1 -: DW];
  assign alu.B_out   = idx[DW-1:0];

  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] fvec_q, fvec_d;
  logic [DW-1:0]    fy_q, fy_d;
  logic             ff_q, ff_d;      // first mismatch already captured
  logic             pass_q, pass_d;
  logic             mism;

  assign mism = cmp_en &&
                (alu.Y_in != alu4_expect(alu.SEL_out, alu.A_out, alu.B_out));

  always_comb begin
    err_d  = err_q;
    fvec_d = fvec_q;
    fy_d   = fy_q;
    ff_d   = ff_q;
    pass_d = pass_q;
    if (clr) begin
      err_d  = '0;
      fvec_d = '0;
      fy_d   = '0;
      ff_d   = 1'b0;
      pass_d = 1'b0;
    end else begin
      if (mism) begin
        err_d = err_q + ERR_W'(1);
        if (!ff_q) begin
          fvec_d = idx;
          fy_d   = alu.Y_in;
          ff_d   = 1'b1;
        end
      end
      // PASS is settled on the same edge that raises DONE.
      if (last) pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge CLK_in or negedge RST_N_in) begin
    if (!RST_N_in) begin
      err_q  <= '0;
      fvec_q <= '0;
      fy_q   <= '0;
      ff_q   <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      fvec_q <= fvec_d;
      fy_q   <= fy_d;
      ff_q   <= ff_d;
      pass_q <= pass_d;
    end
  end

  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fvec_q;
  assign FAIL_Y   = fy_q;
  assign PASS     = pass_q;

endmodule
